lane_mem_responder: RTL and testbench
=====================================

Name: lane_mem_responder

Overview:
- Multi-lane word memory that serves the per-lane read/write port bundle driven by the GPU lane compute engines.
- Each lane gets two combinational read ports (A, B) and one synchronous write port.
- A single-word host port (valid/ready request, valid/ready response) lets the testbench or control processor preload operands and read back results while the engine is idle.
- Sits between the engine and the shared operand/result storage; it is the responder side of the engine's lane memory interface.

Parameters:
- LANES, lanes (GPU_Shader_pkg), number of parallel lanes / port sets.
- DEPTH, MEM_DEPTH (GPU_Shader_pkg), number of word_t entries.
- AW, $clog2(DEPTH), address width (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- eng_raddrA  in  AW x LANES  per-lane read address, port A.
- eng_raddrB  in  AW x LANES  per-lane read address, port B.
- eng_rdataA  out  word_t x LANES  combinational read data, port A.
- eng_rdataB  out  word_t x LANES  combinational read data, port B.
- eng_wen  in  LANES  per-lane write enable.
- eng_waddr  in  AW x LANES  per-lane write address.
- eng_wdata  in  word_t x LANES  per-lane write data.
- eng_busy  in  1  engine-busy indication; blocks host requests.
- host_req_valid  in  1  host request valid.
- host_req_ready  out  1  host request accept.
- host_req_we  in  1  1 = write, 0 = read.
- host_req_addr  in  AW  host word address.
- host_req_wdata  in  word_t  host write data.
- host_rsp_valid  out  1  response valid.
- host_rsp_ready  in  1  response consume.
- host_rsp_rdata  out  word_t  read data; 0 for write acknowledgements.
- collision_cnt  out  16  saturating count of same-address lane write conflicts (see Optional Feature).

Behaviour:
- Storage: DEPTH x word_t array. Contents are not reset and are X after power-up.
- Engine reads: combinational, zero latency. Data equals the array contents before the current edge's writes, so there is no write-to-read bypass.
- Read address >= DEPTH returns 0.
- Engine writes: committed on the rising edge when eng_wen[i]=1 and the address is < DEPTH. Out-of-range writes are dropped silently.
- Same-edge write conflict, two or more lanes to the same address: the highest lane index wins.
- Conflict counting: each edge with at least one conflicting address increments collision_cnt by 1, regardless of how many lanes collide. The counter saturates at 0xFFFF.
- Host FSM has two states, H_IDLE and H_RSP.
- host_req_ready = (state==H_IDLE) && !eng_busy. It is combinational from registered state and the eng_busy input.
- H_IDLE, on valid&&ready:
  - Write: array updated at this edge. If eng_wen hits the same address on the same edge, the engine write wins. host_rsp_rdata <= 0.
  - Read: host_rsp_rdata <= array value before this edge's writes.
  - Either way: host_rsp_valid <= 1, go to H_RSP. Response latency is exactly 1 cycle after acceptance.
- H_RSP: host_rsp_valid and host_rsp_rdata are held stable until host_rsp_ready=1. At that edge host_rsp_valid <= 0 and the FSM goes to H_IDLE. No new request is accepted in the same cycle (one outstanding request at most).
- eng_busy rising while in H_RSP does not affect the pending response.
- Reset (async, any time): state=H_IDLE, host_rsp_valid=0, host_rsp_rdata=0, collision_cnt=0. Any in-flight response is discarded. Array contents are retained.
- host_req_ready after reset = !eng_busy.

Optional Feature:
- Macro: LANE_COLLISION_CNT_EN.
- Defined: conflict detection logic and the collision_cnt counter are built as described.
- Undefined: no detection logic is built and collision_cnt is tied to 0. Highest-lane-wins write priority still applies.

Test Plan:
- Host writes 0x11 to addr 5 with host_rsp_ready=1 throughout -> host_rsp_valid exactly 1 cycle after accept with rdata 0. A following host read of addr 5 returns 0x11 one cycle after accept.
- Host preloads A[0..3]={1,2,3,4} and B[0..3]={10,20,30,40}. Drive LANES=4 eng_raddrA/B=0..3 and eng_wen=4'hF to addr 8..11 with wdata=A+B -> eng_rdataA/B correct in the same cycle. Host readback of 8..11 = {11,22,33,44}.
- Lanes 0 and 2 both write addr 3, data 0xAA and 0xBB -> addr 3 holds 0xBB. collision_cnt = 1 with LANE_COLLISION_CNT_EN, 0 without.
- eng_busy=1 while host_req_valid=1 -> host_req_ready=0 for the whole busy window. The request is accepted on the first cycle after eng_busy falls.
- Read response with host_rsp_ready held 0 for 5 cycles -> valid and rdata stable for all 5 cycles, host_req_ready=0. Assert rsp_ready -> valid drops next cycle.
- Assert rst_n=0 while in H_RSP -> host_rsp_valid=0 and collision_cnt=0 immediately (asynchronous). A previously written memory word reads back unchanged after reset release.

Source files
------------

// File: rtl/lane_mem_responder.sv
// lane_mem_responder: multi-lane word memory answering the GPU lane engines.
// Each lane has two combinational read ports (A, B) and one synchronous write
// port. A single-word host port preloads operands and reads back results
// while the engine is idle.
// Optional feature macro: LANE_COLLISION_CNT_EN builds same-address lane write
// conflict detection and the saturating collision_cnt counter. Without it,
// collision_cnt is tied to 0. Highest-lane-wins write priority applies in
// both builds.
//
// Handshake rule for the host port: a transfer happens on a rising edge where
// valid and ready are both 1. A valid response is held, with its data
// unchanged, until it is consumed. At most one host request is outstanding.

package GPU_Shader_pkg;
  parameter int lanes     = 4;
  parameter int MEM_DEPTH = 24;
  typedef logic [31:0] word_t;
endpackage

module lane_mem_responder
  import GPU_Shader_pkg::*;
#(
  parameter  int LANES = lanes,
  parameter  int DEPTH = MEM_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int DW    = $bits(word_t)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [LANES-1:0][AW-1:0] eng_raddrA,
  input  logic [LANES-1:0][AW-1:0] eng_raddrB,
  output logic [LANES-1:0][DW-1:0] eng_rdataA,
  output logic [LANES-1:0][DW-1:0] eng_rdataB,
  input  logic [LANES-1:0]         eng_wen,
  input  logic [LANES-1:0][AW-1:0] eng_waddr,
  input  logic [LANES-1:0][DW-1:0] eng_wdata,
  input  logic                     eng_busy,
  input  logic                     host_req_valid,
  output logic                     host_req_ready,
  input  logic                     host_req_we,
  input  logic [AW-1:0]            host_req_addr,
  input  logic [DW-1:0]            host_req_wdata,
  output logic                     host_rsp_valid,
  input  logic                     host_rsp_ready,
  output logic [DW-1:0]            host_rsp_rdata,
  output logic [15:0]              collision_cnt,
  output logic                     host_state_dbg
);

  typedef enum logic {H_IDLE = 1'b0, H_RSP = 1'b1} host_state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  host_state_t state;
  logic [DW-1:0] mem [DEPTH];
  logic          host_acc;
  logic [DW-1:0] host_rd_data;

  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_W);
  endfunction

  assign host_req_ready = (state == H_IDLE) && !eng_busy;
  assign host_acc       = host_req_valid && host_req_ready;
  assign host_state_dbg = (state == H_RSP);

  // Engine read ports: zero latency, pre-edge contents, out-of-range reads give 0.
  always_comb begin
    eng_rdataA = '0;
    eng_rdataB = '0;
    for (int i = 0; i < LANES; i++) begin
      if (in_range(eng_raddrA[i])) eng_rdataA[i] = mem[eng_raddrA[i]];
      if (in_range(eng_raddrB[i])) eng_rdataB[i] = mem[eng_raddrB[i]];
    end
  end

  // Host read value, taken from the array before this edge's writes.
  always_comb begin
    host_rd_data = '0;
    if (in_range(host_req_addr)) host_rd_data = mem[host_req_addr];
  end

  // Storage writes, which are not reset. The host write goes first and lanes
  // follow in ascending order, so the later assignment wins: the engine beats
  // the host, and the highest lane index beats lower lanes.
  always_ff @(posedge clk) begin
    if (host_acc && host_req_we && in_range(host_req_addr))
      mem[host_req_addr] <= host_req_wdata;
    for (int i = 0; i < LANES; i++) begin
      if (eng_wen[i] && in_range(eng_waddr[i]))
        mem[eng_waddr[i]] <= eng_wdata[i];
    end
  end

  // Host FSM: accept in H_IDLE, then hold the response in H_RSP until it is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= H_IDLE;
      host_rsp_valid <= 1'b0;
      host_rsp_rdata <= '0;
    end else begin
      case (state)
        H_IDLE: begin
          if (host_acc) begin
            host_rsp_rdata <= host_req_we ? '0 : host_rd_data;
            host_rsp_valid <= 1'b1;
            state          <= H_RSP;
          end
        end
        H_RSP: begin
          if (host_rsp_ready) begin
            host_rsp_valid <= 1'b0;
            state          <= H_IDLE;
          end
        end
        default: state <= H_IDLE;
      endcase
    end
  end

`ifdef LANE_COLLISION_CNT_EN
  logic conflict;

  // Flag an edge where two or more lanes write the same in-range address.
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (eng_wen[i] && eng_wen[j] && (eng_waddr[i] == eng_waddr[j]) &&
            in_range(eng_waddr[i]))
          conflict = 1'b1;
      end
    end
  end

  // Count conflicting edges, one per edge at most, saturating at all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) collision_cnt <= '0;
    else if (conflict && (collision_cnt != 16'hFFFF)) collision_cnt <= collision_cnt + 16'd1;
  end
`else
  assign collision_cnt = '0;
`endif

endmodule

// File: tb/tb_lane_mem_responder.sv
// Directed testbench for lane_mem_responder with hand-computed expectations.
module tb_lane_mem_responder;
  localparam int LANES = 4;
  localparam int DEPTH = 24;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic                     clk;
  logic                     rst_n;
  logic [LANES-1:0][AW-1:0] eng_raddrA;
  logic [LANES-1:0][AW-1:0] eng_raddrB;
  logic [LANES-1:0][DW-1:0] eng_rdataA;
  logic [LANES-1:0][DW-1:0] eng_rdataB;
  logic [LANES-1:0]         eng_wen;
  logic [LANES-1:0][AW-1:0] eng_waddr;
  logic [LANES-1:0][DW-1:0] eng_wdata;
  logic                     eng_busy;
  logic                     host_req_valid;
  logic                     host_req_ready;
  logic                     host_req_we;
  logic [AW-1:0]            host_req_addr;
  logic [DW-1:0]            host_req_wdata;
  logic                     host_rsp_valid;
  logic                     host_rsp_ready;
  logic [DW-1:0]            host_rsp_rdata;
  logic [15:0]              collision_cnt;
  logic                     host_state_dbg;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

`ifdef LANE_COLLISION_CNT_EN
  localparam logic [15:0] COLL_STEP = 16'd1;
`else
  localparam logic [15:0] COLL_STEP = 16'd0;
`endif

  lane_mem_responder #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .eng_raddrA(eng_raddrA), .eng_raddrB(eng_raddrB),
    .eng_rdataA(eng_rdataA), .eng_rdataB(eng_rdataB),
    .eng_wen(eng_wen), .eng_waddr(eng_waddr), .eng_wdata(eng_wdata),
    .eng_busy(eng_busy),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
    .host_req_we(host_req_we), .host_req_addr(host_req_addr),
    .host_req_wdata(host_req_wdata),
    .host_rsp_valid(host_rsp_valid), .host_rsp_ready(host_rsp_ready),
    .host_rsp_rdata(host_rsp_rdata),
    .collision_cnt(collision_cnt), .host_state_dbg(host_state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Driver: present a host request and wait (bounded) for it to be accepted.
  // Returns #1 after the accepting edge.
  task automatic host_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    int waited;
    waited = 0;
    host_req_valid = 1'b1;
    host_req_we    = we;
    host_req_addr  = addr;
    host_req_wdata = wd;
    @(negedge clk);
    while (!host_req_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!host_req_ready) chk("req_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    host_req_valid = 1'b0;
  endtask

  // Full host transaction with host_rsp_ready=1: response one cycle after accept, then consumed.
  task automatic host_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [DW-1:0] exp, input string tag);
    host_req(we, addr, wd);
    chk({tag, "_vld"}, {31'd0, host_rsp_valid}, 32'd1);
    chk({tag, "_data"}, host_rsp_rdata, exp);
    @(posedge clk);
    #1;
    chk({tag, "_drop"}, {31'd0, host_rsp_valid}, 32'd0);
  endtask

  initial begin
    logic [DW-1:0] e;
    rst_n = 1'b0;
    eng_raddrA = '0; eng_raddrB = '0; eng_wen = '0; eng_waddr = '0; eng_wdata = '0;
    eng_busy = 1'b1;
    host_req_valid = 1'b0; host_req_we = 1'b0; host_req_addr = '0; host_req_wdata = '0;
    host_rsp_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_ready_busy", {31'd0, host_req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, host_rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", host_rsp_rdata, 32'd0);
    chk("rst_coll", {16'd0, collision_cnt}, 32'd0);
    eng_busy = 1'b0;
    #1;
    chk("rst_ready_idle", {31'd0, host_req_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Host write then read of addr 5
    host_op(1'b1, 5'd5, 32'h11, 32'h0, "hw5");
    host_op(1'b0, 5'd5, 32'h0, 32'h11, "hr5");

    // Preload A at 0..3 and B at 4..7
    for (int i = 0; i < 4; i++) begin
      host_op(1'b1, AW'(i), DW'(i + 1), 32'h0, "pre_a");
      host_op(1'b1, AW'(4 + i), DW'(10 * (i + 1)), 32'h0, "pre_b");
    end

    // Engine reads A/B and writes A+B to 8..11 in one cycle
    for (int i = 0; i < LANES; i++) begin
      eng_raddrA[i] = AW'(i);
      eng_raddrB[i] = AW'(4 + i);
      eng_waddr[i]  = AW'(8 + i);
      eng_wdata[i]  = DW'(11 * (i + 1));
      exp_q.push_back(DW'(11 * (i + 1)));
    end
    eng_wen = 4'hF;
    #2;
    for (int i = 0; i < LANES; i++) begin
      chk("eng_rdA", eng_rdataA[i], DW'(i + 1));
      chk("eng_rdB", eng_rdataB[i], DW'(10 * (i + 1)));
    end
    @(posedge clk);
    #1;
    eng_wen = '0;
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      host_op(1'b0, AW'(8 + i), 32'h0, e, "sum_rb");
    end

    // No write-to-read bypass; out-of-range reads return 0
    eng_raddrA[0] = 5'd12; eng_waddr[0] = 5'd12; eng_wdata[0] = 32'h12; eng_wen = 4'b0001;
    @(posedge clk);
    #1;
    eng_wdata[0] = 32'h34;
    #1;
    chk("no_bypass", eng_rdataA[0], 32'h12);
    @(posedge clk);
    #1;
    eng_wen = '0;
    #1;
    chk("after_wr", eng_rdataA[0], 32'h34);
    eng_raddrB[1] = 5'd30;
    #1;
    chk("oor_read", eng_rdataB[1], 32'h0);

    // Lane conflict: lanes 0 and 2 to addr 3, lane 2 wins
    eng_waddr[0] = 5'd3; eng_wdata[0] = 32'hAA;
    eng_waddr[2] = 5'd3; eng_wdata[2] = 32'hBB;
    eng_wen = 4'b0101;
    @(posedge clk);
    #1;
    eng_wen = '0;
    eng_raddrA[0] = 5'd3;
    #1;
    chk("coll_data", eng_rdataA[0], 32'hBB);
    chk("coll_cnt1", {16'd0, collision_cnt}, {16'd0, COLL_STEP});

    // Three lanes on one address count once; lane 3 wins
    for (int i = 1; i < 4; i++) begin
      eng_waddr[i] = 5'd13;
      eng_wdata[i] = DW'(i);
    end
    eng_wen = 4'b1110;
    @(posedge clk);
    #1;
    eng_wen = '0;
    eng_raddrA[0] = 5'd13;
    #1;
    chk("coll3_data", eng_rdataA[0], 32'h3);
    chk("coll_cnt2", {16'd0, collision_cnt}, {16'd0, COLL_STEP + COLL_STEP});

    // Host and engine write the same address on one edge: engine wins
    eng_waddr[1] = 5'd6; eng_wdata[1] = 32'h66; eng_wen = 4'b0010;
    host_req(1'b1, 5'd6, 32'h77);
    eng_wen = '0;
    chk("he_vld", {31'd0, host_rsp_valid}, 32'd1);
    @(posedge clk);
    #1;
    host_op(1'b0, 5'd6, 32'h0, 32'h66, "he_rb");

    // eng_busy blocks the host request for the whole busy window
    eng_busy = 1'b1;
    host_req_valid = 1'b1; host_req_we = 1'b1; host_req_addr = 5'd20; host_req_wdata = 32'h55;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("busy_block", {31'd0, host_req_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    eng_busy = 1'b0;
    @(negedge clk);
    chk("busy_release", {31'd0, host_req_ready}, 32'd1);
    @(posedge clk);
    #1;
    host_req_valid = 1'b0;
    chk("busy_acc_vld", {31'd0, host_rsp_valid}, 32'd1);
    chk("busy_acc_data", host_rsp_rdata, 32'h0);
    @(posedge clk);
    #1;

    // Response held while host_rsp_ready=0; eng_busy mid-hold has no effect
    host_rsp_ready = 1'b0;
    host_req(1'b0, 5'd20, 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_vld", {31'd0, host_rsp_valid}, 32'd1);
      chk("hold_data", host_rsp_rdata, 32'h55);
      chk("hold_ready", {31'd0, host_req_ready}, 32'd0);
      if (k == 2) eng_busy = 1'b1;
    end
    eng_busy = 1'b0;
    host_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_drop", {31'd0, host_rsp_valid}, 32'd0);

    // Asynchronous reset during H_RSP; memory survives
    host_rsp_ready = 1'b0;
    host_req(1'b0, 5'd3, 32'h0);
    chk("pre_rst_vld", {31'd0, host_rsp_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_vld", {31'd0, host_rsp_valid}, 32'd0);
    chk("arst_data", host_rsp_rdata, 32'h0);
    chk("arst_coll", {16'd0, collision_cnt}, 32'd0);
    chk("arst_state", {31'd0, host_state_dbg}, 32'd0);
    chk("arst_ready", {31'd0, host_req_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    host_rsp_ready = 1'b1;
    host_op(1'b0, 5'd20, 32'h0, 32'h55, "keep20");
    host_op(1'b0, 5'd3, 32'h0, 32'hBB, "keep3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
